chan_fill_pipe: RTL and testbench

Parametrised multi-channel elastic pipeline. Carries CHANNELS lanes of WIDTH bits through DEPTH register stages with a valid/ready handshake. Per-beat lane masking replaces masked lanes with a parameter-selected fill pattern. It is the generalised successor to the fixed single-lane fill logic: channel count, width, depth and fill mode are all parameters, and it adds flow control, flush and occupancy. It sits between a producer and consumer that share one clock domain.

---
 rtl/chan_fill_pkg.sv | 28 ++
 rtl/chan_fill_pipe_if.sv | 35 +++
 rtl/chan_fill_stage.sv | 31 +++
 rtl/chan_fill_pipe.sv | 102 ++++++++++
 tb/tb_chan_fill_pipe.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/chan_fill_pkg.sv
// chan_fill_pkg: shared helpers for the chan_fill_pipe slice.
// Provides fill_word (lane fill pattern) and cnt_width (occupancy width).
package chan_fill_pkg;

    // Upper bound on a lane width that fill_word can describe.
    localparam int MAX_W = 4096;

    // Returns the fill pattern in the low `width` bits; callers slice it.
    function automatic logic [MAX_W-1:0] fill_word(input int width,
                                                   input bit ones);
        logic [MAX_W-1:0] f;
        f = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                f[i] = ones;
            end
        end
        return f;
    endfunction

    // Width of the occupancy counter: max(1, clog2(depth+1)).
    function automatic int cnt_width(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/chan_fill_pipe_if.sv
// chan_fill_pipe_if: producer-side and consumer-side valid/ready bus.
// slave = pipeline view, master = producer/consumer (testbench) view.
interface chan_fill_pipe_if #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic [CHANNELS*WIDTH-1:0]    in_data;
    logic [CHANNELS-1:0]          in_mask;
    logic                         out_valid;
    logic                         out_ready;
    logic [CHANNELS*WIDTH-1:0]    out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_mask,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output in_mask,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

endinterface

// File: rtl/chan_fill_stage.sv
// chan_fill_stage: one valid+data pipeline register.
// Ports: clk, rst, clr (flush), load/drain strobes, din -> v, d.
module chan_fill_stage #(
    parameter int           W    = 24,
    parameter logic [W-1:0] FILL = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] din,
    output logic         v,
    output logic [W-1:0] d
);

    // An empty stage always carries FILL so out_data is FILL when idle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            v <= 1'b0;
            d <= FILL;
        end else if (load) begin
            v <= 1'b1;
            d <= din;
        end else if (drain) begin
            v <= 1'b0;
            d <= FILL;
        end
    end

endmodule

// File: rtl/chan_fill_pipe.sv
// chan_fill_pipe: CHANNELS x WIDTH elastic pipeline, DEPTH stages, lane fill.
// Ports: clk, rst (sync, high), flush, bus (slave handshake), count.
module chan_fill_pipe
    import chan_fill_pkg::*;
#(
    parameter  int CHANNELS  = 3,
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 2,
    parameter  int FILL_ONES = 1,
    localparam int CW        = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    chan_fill_pipe_if.slave   bus,
    output logic [CW-1:0]     count
);

    localparam int DW = CHANNELS * WIDTH;
    localparam logic [MAX_W-1:0] FW = fill_word(WIDTH, FILL_ONES != 0);
    localparam logic [WIDTH-1:0] LFILL = FW[WIDTH-1:0];
    localparam logic [DW-1:0]    WFILL = {CHANNELS{LFILL}};

    logic [DW-1:0] md;

    always_comb begin
        md = bus.in_data;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.in_mask[c]) begin
                md[c*WIDTH +: WIDTH] = LFILL;
            end
        end
    end

    generate
        if (DEPTH == 0) begin : g_comb
            // No state here, so clk and rst are intentionally unused.
            wire unused_clk_rst = clk ^ rst;

            assign bus.out_valid = bus.in_valid & ~flush;
            assign bus.in_ready  = bus.out_ready & ~flush;
            assign bus.out_data  = md;
            assign count         = '0;
        end else begin : g_pipe
            logic [DEPTH-1:0] v;
            logic [DEPTH-1:0] adv;
            logic [DW-1:0]    d [DEPTH];
            logic             acc;

            // A stage may advance if it is empty or the next one advances;
            // out_ready ripples all the way to in_ready with no bubble.
            always_comb begin
                adv = '0;
                adv[DEPTH-1] = ~v[DEPTH-1] | bus.out_ready;
                for (int k = DEPTH - 2; k >= 0; k--) begin
                    adv[k] = ~v[k] | adv[k+1];
                end
            end

            assign bus.in_ready = adv[0] & ~flush & ~rst;
            assign acc          = bus.in_valid & bus.in_ready;

            for (genvar k = 0; k < DEPTH; k++) begin : g_stage
                logic          vin;
                logic [DW-1:0] din;

                if (k == 0) begin : g_head
                    assign vin = acc;
                    assign din = md;
                end else begin : g_body
                    assign vin = v[k-1];
                    assign din = d[k-1];
                end

                chan_fill_stage #(
                    .W    (DW),
                    .FILL (WFILL)
                ) u_stage (
                    .clk   (clk),
                    .rst   (rst),
                    .clr   (flush),
                    .load  (adv[k] & vin),
                    .drain (adv[k] & ~vin),
                    .din   (din),
                    .v     (v[k]),
                    .d     (d[k])
                );
            end

            assign bus.out_valid = v[DEPTH-1];
            assign bus.out_data  = d[DEPTH-1];

            always_comb begin
                count = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    count = count + CW'(v[k]);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_chan_fill_pipe.sv
// tb_chan_fill_pipe: scoreboard bench for chan_fill_pipe.
// Ones-fill and zeros-fill DEPTH=2 units share stimulus; a DEPTH=0 unit runs beside.
module tb_chan_fill_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic flush2 = 1'b0;
    logic [1:0] cnt0;
    logic [1:0] cnt1;
    logic [0:0] cnt2;
    bit mon_on = 1'b0;
    bit pend = 1'b0;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    chan_fill_pipe_if #(.CHANNELS(3), .WIDTH(8)) if0 ();
    chan_fill_pipe_if #(.CHANNELS(3), .WIDTH(8)) if1 ();
    chan_fill_pipe_if #(.CHANNELS(4), .WIDTH(3)) if2 ();

    assign if1.in_valid  = if0.in_valid;
    assign if1.in_data   = if0.in_data;
    assign if1.in_mask   = if0.in_mask;
    assign if1.out_ready = if0.out_ready;

    chan_fill_pipe #(.CHANNELS(3), .WIDTH(8), .DEPTH(2), .FILL_ONES(1))
        u0 (.clk(clk), .rst(rst), .flush(flush), .bus(if0), .count(cnt0));
    chan_fill_pipe #(.CHANNELS(3), .WIDTH(8), .DEPTH(2), .FILL_ONES(0))
        u1 (.clk(clk), .rst(rst), .flush(flush), .bus(if1), .count(cnt1));
    chan_fill_pipe #(.CHANNELS(4), .WIDTH(3), .DEPTH(0), .FILL_ONES(1))
        u2 (.clk(clk), .rst(rst), .flush(flush2), .bus(if2), .count(cnt2));

    typedef struct {
        logic [23:0] e1;
        logic [23:0] e0;
    } exp_t;

    exp_t q[$];

    // Reference: each lane is either its own input bits or the fill value.
    function automatic logic [31:0] fillm(logic [31:0] d, logic [3:0] m,
                                          int ch, int w, bit ones);
        logic [31:0] r;
        logic [31:0] lm;
        logic [31:0] lane;
        r = 0;
        lm = (32'd1 << w) - 32'd1;
        for (int c = 0; c < ch; c++) begin
            if (m[c]) lane = ones ? lm : 32'd0;
            else lane = (d >> (c * w)) & lm;
            r = r | (lane << (c * w));
        end
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on delivery and checks the rules.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("count0", 64'(cnt0), 64'(q.size()));
            chk("count1", 64'(cnt1), 64'(q.size()));
            chk("ready0", 64'(if0.in_ready),
                64'(!flush && !rst && (q.size() < 2 || if0.out_ready)));
            chk("ready1", 64'(if1.in_ready),
                64'(!flush && !rst && (q.size() < 2 || if0.out_ready)));
            if (q.size() == 2) begin
                chk("full_v0", 64'(if0.out_valid), 64'(1));
                chk("full_v1", 64'(if1.out_valid), 64'(1));
            end
            if (q.size() == 0) begin
                chk("empty_v0", 64'(if0.out_valid), 64'(0));
                chk("empty_v1", 64'(if1.out_valid), 64'(0));
            end
            if (!if0.out_valid) chk("idle_d0", 64'(if0.out_data), 64'hFFFFFF);
            if (!if1.out_valid) chk("idle_d1", 64'(if1.out_data), 64'h0);
            if (if0.out_valid && if0.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL underflow actual=%0h required=none",
                             if0.out_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("data_ones", 64'(if0.out_data), 64'(e.e1));
                    chk("valid_u1", 64'(if1.out_valid), 64'(1));
                    chk("data_zeros", 64'(if1.out_data), 64'(e.e0));
                end
            end
            chk("z_valid", 64'(if2.out_valid), 64'(if2.in_valid && !flush2));
            chk("z_ready", 64'(if2.in_ready), 64'(if2.out_ready && !flush2));
            chk("z_data", 64'(if2.out_data),
                64'(fillm(32'(if2.in_data), if2.in_mask, 4, 3, 1'b1)));
            chk("z_count", 64'(cnt2), 64'(0));
        end
    end

    // One cycle: record the accept/clear, then move to just after the edge.
    task automatic tick();
        @(negedge clk);
        #2;
        if (if0.in_valid && if0.in_ready) begin
            exp_t e;
            e.e1 = 24'(fillm(32'(if0.in_data), 4'(if0.in_mask), 3, 8, 1'b1));
            e.e0 = 24'(fillm(32'(if0.in_data), 4'(if0.in_mask), 3, 8, 1'b0));
            q.push_back(e);
        end
        if (flush || rst) q.delete();
        pend = if0.in_valid && !if0.in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [23:0] d, logic [2:0] m);
        if0.in_valid = 1'b1;
        if0.in_data = d;
        if0.in_mask = m;
        tick();
        if0.in_valid = 1'b0;
    endtask

    initial begin
        if0.in_valid = 1'b0;
        if0.in_data = '0;
        if0.in_mask = '0;
        if0.out_ready = 1'b1;
        if2.in_valid = 1'b0;
        if2.in_data = '0;
        if2.in_mask = '0;
        if2.out_ready = 1'b0;

        @(posedge clk);
        #1;
        mon_on = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(if0.out_valid), 64'(0));
        chk("rst_data", 64'(if0.out_data), 64'hFFFFFF);
        chk("rst_count", 64'(cnt0), 64'(0));
        chk("rst_ready", 64'(if0.in_ready), 64'(1));

        // single beat: latency 2
        push(24'h123456, 3'b000);
        chk("lat1_valid", 64'(if0.out_valid), 64'(0));
        chk("lat1_count", 64'(cnt0), 64'(1));
        tick();
        chk("lat2_valid", 64'(if0.out_valid), 64'(1));
        chk("lat2_data", 64'(if0.out_data), 64'h123456);
        tick();
        chk("lat_drain", 64'(cnt0), 64'(0));

        // lane mask
        push(24'hAABBCC, 3'b010);
        tick();
        chk("mask_ones", 64'(if0.out_data), 64'hAAFFCC);
        chk("mask_zeros", 64'(if1.out_data), 64'hAA00CC);
        tick();

        // backpressure, then same-cycle ready release
        if0.out_ready = 1'b0;
        push(24'h111111, 3'b000);
        push(24'h222222, 3'b000);
        push(24'h333333, 3'b100);
        chk("bp_count", 64'(cnt0), 64'(2));
        if0.in_valid = 1'b1;
        #1;
        chk("bp_ready_lo", 64'(if0.in_ready), 64'(0));
        if0.out_ready = 1'b1;
        #1;
        chk("bp_ready_hi", 64'(if0.in_ready), 64'(1));
        tick();
        if0.in_valid = 1'b0;
        repeat (3) tick();

        // flush a full pipe with input offered
        if0.out_ready = 1'b0;
        push(24'h444444, 3'b000);
        push(24'h555555, 3'b000);
        if0.in_valid = 1'b1;
        if0.in_data = 24'h666666;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if0.in_valid = 1'b0;
        chk("fl_count", 64'(cnt0), 64'(0));
        chk("fl_valid", 64'(if0.out_valid), 64'(0));
        chk("fl_data", 64'(if0.out_data), 64'hFFFFFF);
        if0.out_ready = 1'b1;
        repeat (3) tick();

        // reset mid-stream
        if0.out_ready = 1'b0;
        push(24'h777777, 3'b000);
        push(24'h888888, 3'b001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_valid", 64'(if0.out_valid), 64'(0));
        chk("mr_count", 64'(cnt0), 64'(0));
        chk("mr_data", 64'(if0.out_data), 64'hFFFFFF);
        if0.out_ready = 1'b1;
        push(24'h010203, 3'b000);
        tick();
        chk("mr_beat_v", 64'(if0.out_valid), 64'(1));
        chk("mr_beat_d", 64'(if0.out_data), 64'h010203);
        tick();

        // DEPTH=0 directed
        if2.in_valid = 1'b1;
        if2.in_data = 12'hABC;
        if2.in_mask = 4'b0100;
        if2.out_ready = 1'b1;
        #1;
        chk("z0_data", 64'(if2.out_data), 64'hBFC);
        chk("z0_ready", 64'(if2.in_ready), 64'(1));
        if2.out_ready = 1'b0;
        #1;
        chk("z0_ready_lo", 64'(if2.in_ready), 64'(0));
        tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (!pend) begin
                if0.in_valid = $urandom_range(0, 3) != 0;
                if0.in_data = 24'($urandom);
                if0.in_mask = 3'($urandom);
            end
            if0.out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 39) == 0;
            rst = $urandom_range(0, 79) == 0;
            if2.in_valid = 1'($urandom);
            if2.in_data = 12'($urandom);
            if2.in_mask = 4'($urandom);
            if2.out_ready = 1'($urandom);
            flush2 = $urandom_range(0, 7) == 0;
            tick();
        end

        if0.in_valid = 1'b0;
        flush = 1'b0;
        rst = 1'b0;
        if0.out_ready = 1'b1;
        repeat (4) tick();
        chk("end_empty", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
